tap_bscan_ctrl: RTL and testbench
=================================

Name: tap_bscan_ctrl

Overview:
- IEEE 1149.1-style TAP controller that drives a chain of BC1 boundary-scan cells.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register.
- Generates ShiftBR, ClockBR, UpdateBR and ModeCont for the boundary register (BSR).
- Muxes the BSR, bypass and IR serial paths onto TDO.

Parameters:
- IR_WIDTH, 4, instruction register width (min 2).
- EXTEST_OP, 4'b0000, EXTEST opcode; selects BSR, ModeCont=1.
- SAMPLE_OP, 4'b0001, SAMPLE/PRELOAD opcode; selects BSR, ModeCont=0.
- IDCODE_OP, 4'b0010, IDCODE opcode; only meaningful with IDCODE_EN.
- IDCODE_VALUE, 32'h1000_0001, device ID; bit0 must be 1.

Ports:
- Clock, input, 1: TCK; all FSM state changes on rising edge.
- Reset, input, 1: asynchronous, active-high.
- TMS, input, 1: test mode select, sampled on rising Clock.
- TDI, input, 1: serial data in; also routed to the first BC1 TDI by top level.
- TDO_BSR, input, 1: serial out of the last BC1 in the chain.
- ShiftBR, output, 1: BC1 mux select; 1 = shift (TDI), 0 = capture (Din).
- ClockBR, output, 1: gated Clock to the BC1 capture/shift flops.
- UpdateBR, output, 1: update strobe to the BC1 chain.
- ModeCont, output, 1: BC1 output mux select; 1 = test data drives Dout.
- TDO, output, 1: serial data out.
- TDO_EN, output, 1: high while TDO is valid.

Behaviour:
- FSM has the standard 16 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Transitions follow the 1149.1 TMS table. From any state, 5 consecutive TMS=1 reaches TLR.
- Reset forces TLR asynchronously, including mid-shift.
- In TLR:
  - IR resets to all-ones (BYPASS), or to IDCODE_OP with IDCODE_EN.
  - ModeCont=0, ShiftBR=0, UpdateBR=0, TDO=0, TDO_EN=0, bypass flop=0.
  - All of the above also apply on Reset.
- IR path:
  - CapIR loads the IR shift register with {0..0,1,0}, LSBs = 2'b01.
  - ShIR shifts LSB-first: TDI into the MSB, LSB out to TDO.
  - On the falling Clock edge in UpdIR, the shift value moves into the active IR.
  - Undefined opcodes decode as BYPASS.
- DR path, with BSR selected (EXTEST or SAMPLE):
  - ShiftBR=1 in ShDR, 0 otherwise (combinational from state).
  - ClockBR = Clock AND en, with en = (state is CapDR or ShDR). en is latched while Clock is low (glitch-free gate), so exactly one ClockBR pulse occurs per CapDR/ShDR cycle.
  - UpdateBR is registered on the falling Clock edge: 1 for the falling edge through the next falling edge while the state is UpdDR, else 0.
  - TDO = TDO_BSR.
- DR path, with BYPASS selected:
  - The 1-bit bypass flop captures 0 in CapDR and shifts TDI in ShDR; TDO = bypass flop.
  - ClockBR is held at 0 and UpdateBR stays 0.
- ModeCont = 1 only while the active IR == EXTEST_OP. It changes at UpdIR, so Dout holds functional Din until the instruction update.
- TDO and TDO_EN are registered on the falling Clock edge. TDO_EN=1 only when the current state is ShDR or ShIR; otherwise TDO=0.
- Simultaneous events: Reset dominates TMS. TMS=1 in ShDR still shifts that cycle, then moves to Ex1DR.
- Pause states: no ClockBR pulses and no UpdateBR; shift contents are held.

Optional Feature:
- Macro: TAP_IDCODE_EN.
- Defined:
  - Adds a 32-bit ID register that loads IDCODE_VALUE in CapDR and shifts LSB-first in ShDR.
  - Selected by IDCODE_OP; TLR/Reset loads IDCODE_OP into the IR.
  - BSR lines behave as for BYPASS.
- Undefined:
  - No ID register; IDCODE_OP decodes as BYPASS.
  - TLR/Reset loads all-ones.

Test Plan:
- Reset mid-ShDR (after 3 shifts) -> state TLR; IR=4'hF (4'h2 with IDCODE_EN); ModeCont=0, UpdateBR=0, TDO_EN=0.
- From RTI, TMS=1,1,1,1,1 from each of the 16 states -> TLR within 5 clocks.
- Load EXTEST: shift IR with TDI=0000 -> captured TDO sequence 1,0,0,0; ModeCont rises on the UpdIR falling edge.
- EXTEST DR scan of a 4-cell BC1 chain with TDI 1,0,1,1 -> 1 capture + 4 shift ClockBR pulses; ShiftBR=1 for exactly 4 cycles; one UpdateBR pulse; Dout = 1,1,0,1 cell order.
- BYPASS: shift 8 bits 10110011 through DR -> TDO echoes them delayed 1 Clock, first bit 0; ClockBR stays 0.
- With TAP_IDCODE_EN: Reset, then CapDR + 32 ShDR -> TDO returns 32'h1000_0001 LSB-first.

Source files
------------

// File: rtl/tap_bscan_ctrl.sv
`timescale 1ns/1ps
// tap_bscan_ctrl: IEEE 1149.1-style TAP controller driving a chain of BC1 boundary-scan cells.
// Define TAP_IDCODE_EN to add the 32-bit ID register selected by IDCODE_OP.
module tap_bscan_ctrl #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [IR_WIDTH-1:0] EXTEST_OP    = 4'b0000,
    parameter logic [IR_WIDTH-1:0] SAMPLE_OP    = 4'b0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 4'b0010,
    parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001
) (
    input  logic Clock,
    input  logic Reset,
    input  logic TMS,
    input  logic TDI,
    input  logic TDO_BSR,
    output logic ShiftBR,
    output logic ClockBR,
    output logic UpdateBR,
    output logic ModeCont,
    output logic TDO,
    output logic TDO_EN
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};
`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_OP;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = '1;
`endif

    typedef enum logic [3:0] {
        TLR      = 4'h0, RTI      = 4'h1, SEL_DR   = 4'h2, CAP_DR   = 4'h3,
        SH_DR    = 4'h4, EX1_DR   = 4'h5, PAUSE_DR = 4'h6, EX2_DR   = 4'h7,
        UPD_DR   = 4'h8, SEL_IR   = 4'h9, CAP_IR   = 4'hA, SH_IR    = 4'hB,
        EX1_IR   = 4'hC, PAUSE_IR = 4'hD, EX2_IR   = 4'hE, UPD_IR   = 4'hF
    } tap_state_t;

    tap_state_t          state, next_state;
    logic                in_tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
    logic [IR_WIDTH-1:0] ir_shift, ir;
    logic                sel_bsr, bypass_ff, clk_en, dr_tdo;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= TLR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = TMS ? TLR      : RTI;
            RTI:      next_state = TMS ? SEL_DR   : RTI;
            SEL_DR:   next_state = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = TMS ? EX1_DR   : SH_DR;
            SH_DR:    next_state = TMS ? EX1_DR   : SH_DR;
            EX1_DR:   next_state = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = TMS ? UPD_DR   : SH_DR;
            UPD_DR:   next_state = TMS ? SEL_DR   : RTI;
            SEL_IR:   next_state = TMS ? TLR      : CAP_IR;
            CAP_IR:   next_state = TMS ? EX1_IR   : SH_IR;
            SH_IR:    next_state = TMS ? EX1_IR   : SH_IR;
            EX1_IR:   next_state = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = TMS ? UPD_IR   : SH_IR;
            UPD_IR:   next_state = TMS ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    always_comb begin
        in_tlr = (state == TLR);
        cap_dr = (state == CAP_DR);
        sh_dr  = (state == SH_DR);
        upd_dr = (state == UPD_DR);
        cap_ir = (state == CAP_IR);
        sh_ir  = (state == SH_IR);
        upd_ir = (state == UPD_IR);
    end

    // Instruction shift path: capture the fixed 01 pattern, then shift LSB-first.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)      ir_shift <= IR_CAPTURE;
        else if (cap_ir) ir_shift <= IR_CAPTURE;
        else if (sh_ir)  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
    end

    always_ff @(negedge Clock or posedge Reset) begin
        if (Reset)       ir <= IR_RESET;
        else if (in_tlr) ir <= IR_RESET;
        else if (upd_ir) ir <= ir_shift;
    end

    assign sel_bsr  = (ir == EXTEST_OP) || (ir == SAMPLE_OP);
    assign ModeCont = (ir == EXTEST_OP);
    assign ShiftBR  = sel_bsr & sh_dr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)              bypass_ff <= 1'b0;
        else if (in_tlr || cap_dr) bypass_ff <= 1'b0;
        else if (sh_dr)          bypass_ff <= TDI;
    end

`ifdef TAP_IDCODE_EN
    logic        sel_id;
    logic [31:0] id_reg;

    assign sel_id = (ir == IDCODE_OP);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                 id_reg <= IDCODE_VALUE;
        else if (cap_dr && sel_id) id_reg <= IDCODE_VALUE;
        else if (sh_dr && sel_id)  id_reg <= {TDI, id_reg[31:1]};
    end

    assign dr_tdo = sel_bsr ? TDO_BSR : (sel_id ? id_reg[0] : bypass_ff);
`else
    logic unused_id;

    assign unused_id = ^{IDCODE_VALUE, IDCODE_OP};
    assign dr_tdo    = sel_bsr ? TDO_BSR : bypass_ff;
`endif

    // Falling-edge registers: clock-gate enable (stable through the high phase), update strobe and TDO.
    always_ff @(negedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_en   <= 1'b0;
            UpdateBR <= 1'b0;
            TDO      <= 1'b0;
            TDO_EN   <= 1'b0;
        end else begin
            clk_en   <= sel_bsr & (cap_dr | sh_dr);
            UpdateBR <= sel_bsr & upd_dr;
            TDO_EN   <= sh_dr | sh_ir;
            TDO      <= sh_ir ? ir_shift[0] : (sh_dr ? dr_tdo : 1'b0);
        end
    end

    assign ClockBR = Clock & clk_en;

endmodule

// File: tb/tb_tap_bscan_ctrl.sv
`timescale 1ns/1ps
// tb_tap_bscan_ctrl: directed bench for tap_bscan_ctrl with a 4-cell BC1 chain model.
// Also exercises the ID register when TAP_IDCODE_EN is defined.
module tb_tap_bscan_ctrl;

    logic Clock = 1'b0;
    logic Reset, TMS, TDI;
    logic TDO_BSR, ShiftBR, ClockBR, UpdateBR, ModeCont, TDO, TDO_EN;

    logic [3:0] din = 4'b0000;
    logic [3:0] cap = 4'b0000;
    logic [3:0] upd = 4'b0000;
    logic [3:0] dout;
    logic       shift_sel = 1'b0;

    int checks = 0;
    int errors = 0;
    int clkbr_pulses = 0;
    int upd_pulses = 0;
    int shift_cycles = 0;

    logic [5:0] path_bits [16] = '{6'b000111, 6'b000000, 6'b000001, 6'b000001,
                                   6'b000001, 6'b000101, 6'b000101, 6'b010101,
                                   6'b001101, 6'b000011, 6'b000011, 6'b000011,
                                   6'b001011, 6'b001011, 6'b101011, 6'b011011};
    int path_len [16] = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};

    tap_bscan_ctrl dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO_BSR  (TDO_BSR),
        .ShiftBR  (ShiftBR),
        .ClockBR  (ClockBR),
        .UpdateBR (UpdateBR),
        .ModeCont (ModeCont),
        .TDO      (TDO),
        .TDO_EN   (TDO_EN)
    );

    always #5 Clock = ~Clock;

    // BC1 chain model: mux select is taken from the preceding low phase so the capture edge sees a settled value.
    always @(negedge Clock) shift_sel <= ShiftBR;
    always @(posedge ClockBR) cap <= shift_sel ? {cap[2:0], TDI} : din;
    always @(posedge UpdateBR) upd <= cap;
    assign dout    = ModeCont ? upd : din;
    assign TDO_BSR = cap[3];

    always @(posedge ClockBR) clkbr_pulses <= clkbr_pulses + 1;
    always @(posedge UpdateBR) upd_pulses <= upd_pulses + 1;
    always @(negedge Clock) if (ShiftBR) shift_cycles <= shift_cycles + 1;

    task automatic applyStimulus(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Loads an opcode from RTI, checking the captured 1,0,0,0 pattern and ModeCont around the update edge.
    task automatic shiftIr(input logic [3:0] opcode, input logic mode_before, input logic mode_after);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            #1;
            checkOutput("ir_capture_tdo", {31'd0, TDO}, (i == 0) ? 32'd1 : 32'd0);
            checkOutput("ir_tdo_en", {31'd0, TDO_EN}, 32'd1);
            applyStimulus(i == 3, opcode[i]);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("modecont_before_update", {31'd0, ModeCont}, {31'd0, mode_before});
        @(negedge Clock);
        #1;
        checkOutput("modecont_after_update", {31'd0, ModeCont}, {31'd0, mode_after});
        checkOutput("ir_value", {28'd0, dut.ir}, {28'd0, opcode});
        applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  bp_bits;
        logic [3:0]  tdi_seq;
        logic [3:0]  exp_cap;
        logic [31:0] id_word;
        logic [3:0]  ir_reset_val;
        int          base_clk, base_upd, base_shift;

`ifdef TAP_IDCODE_EN
        ir_reset_val = 4'h2;
`else
        ir_reset_val = 4'hF;
`endif

        // Power-on reset
        Reset = 1'b1;
        TMS   = 1'b1;
        TDI   = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("reset_state", {28'd0, dut.state}, 32'd0);
        checkOutput("reset_ir", {28'd0, dut.ir}, {28'd0, ir_reset_val});
        checkOutput("reset_modecont", {31'd0, ModeCont}, 32'd0);
        checkOutput("reset_shiftbr", {31'd0, ShiftBR}, 32'd0);
        checkOutput("reset_updatebr", {31'd0, UpdateBR}, 32'd0);
        checkOutput("reset_clockbr", {31'd0, ClockBR}, 32'd0);
        checkOutput("reset_tdo", {31'd0, TDO}, 32'd0);
        checkOutput("reset_tdo_en", {31'd0, TDO_EN}, 32'd0);
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Explicit BYPASS load, then 8-bit bypass scan
        shiftIr(4'hF, 1'b0, 1'b0);
        bp_bits  = 8'b10110011;
        base_clk = clkbr_pulses;
        base_upd = upd_pulses;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            @(negedge Clock);
            #1;
            checkOutput("bypass_tdo", {31'd0, TDO}, (j == 0) ? 32'd0 : {31'd0, bp_bits[8 - j]});
            applyStimulus(j == 7, bp_bits[7 - j]);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        @(negedge Clock);
        #1;
        checkOutput("bypass_clockbr_pulses", clkbr_pulses - base_clk, 32'd0);
        checkOutput("bypass_updatebr_pulses", upd_pulses - base_upd, 32'd0);

        // Load EXTEST and scan the 4-cell chain
        shiftIr(4'h0, 1'b0, 1'b1);
        din        = 4'b0110;
        tdi_seq    = 4'b1101;
        exp_cap    = 4'b0110;
        base_clk   = clkbr_pulses;
        base_upd   = upd_pulses;
        base_shift = shift_cycles;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(negedge Clock);
            #1;
            checkOutput("extest_capture_tdo", {31'd0, TDO}, {31'd0, exp_cap[j]});
            checkOutput("extest_shiftbr", {31'd0, ShiftBR}, 32'd1);
            applyStimulus(j == 3, tdi_seq[j]);
        end
        @(negedge Clock);
        #1;
        checkOutput("extest_shiftbr_ex1", {31'd0, ShiftBR}, 32'd0);
        checkOutput("extest_dout_before_update", {28'd0, dout}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        @(negedge Clock);
        #1;
        checkOutput("extest_clockbr_pulses", clkbr_pulses - base_clk, 32'd5);
        checkOutput("extest_shift_cycles", shift_cycles - base_shift, 32'd4);
        checkOutput("extest_updatebr_pulses", upd_pulses - base_upd, 32'd1);
        checkOutput("extest_updatebr_low", {31'd0, UpdateBR}, 32'd0);
        checkOutput("extest_dout", {28'd0, dout}, 32'h0000_000B);

        // Asynchronous reset after three shifts in ShDR
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1);
        @(negedge Clock);
        #1;
        checkOutput("midshift_tdo_en", {31'd0, TDO_EN}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("midshift_reset_state", {28'd0, dut.state}, 32'd0);
        checkOutput("midshift_reset_ir", {28'd0, dut.ir}, {28'd0, ir_reset_val});
        checkOutput("midshift_reset_modecont", {31'd0, ModeCont}, 32'd0);
        checkOutput("midshift_reset_updatebr", {31'd0, UpdateBR}, 32'd0);
        checkOutput("midshift_reset_tdo_en", {31'd0, TDO_EN}, 32'd0);
        checkOutput("midshift_reset_shiftbr", {31'd0, ShiftBR}, 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Five TMS=1 clocks return to TLR from every state
        for (int s = 0; s < 16; s++) begin
            repeat (5) applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            for (int b = 0; b < path_len[s]; b++) applyStimulus(path_bits[s][b], 1'b0);
            checkOutput($sformatf("walk_reach_%0d", s), {28'd0, dut.state}, s);
            repeat (5) applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("walk_tlr_from_%0d", s), {28'd0, dut.state}, 32'd0);
        end

`ifdef TAP_IDCODE_EN
        // ID register readout straight after reset
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        checkOutput("idcode_reset_ir", {28'd0, dut.ir}, 32'd2);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        id_word = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clock);
            #1;
            id_word[i] = TDO;
            applyStimulus(i == 31, 1'b0);
        end
        checkOutput("idcode_value", id_word, 32'h1000_0001);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
`else
        id_word = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
